sram_1w1r_fifo_ctrl: RTL and testbench



---
 rtl/sram_1w1r_fifo_ctrl.sv | 124 ++++++++++++
 tb/tb_sram_1w1r_fifo_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_1w1r_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sram_1w1r_fifo_ctrl
// Brief   : Valid/ready FIFO built on a 1W/1R SRAM macro plus a 2-word
//           output buffer that hides the macro's one-cycle read latency.
// Revision: 1.0
// ============================================================================
module sram_1w1r_fifo_ctrl #(
  parameter int DATA_WIDTH = 40,
  parameter int ADDR_WIDTH = 7,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk0,
  input  logic                  rstb,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  input  logic                  pop_ready,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                  sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  localparam logic [ADDR_WIDTH:0]   C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] C_LAST  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] C_ONE   = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_sram_occ;
  logic [ADDR_WIDTH:0]   r_avail;
  logic                  r_inflight;
  logic [1:0]            r_ob_cnt;
  logic [DATA_WIDTH-1:0] r_ob0;
  logic [DATA_WIDTH-1:0] r_ob1;
  logic [ADDR_WIDTH:0]   r_level;

  logic                  w_push_fire;
  logic                  w_pop_fire;
  logic                  w_issue;
  logic [2:0]            w_ob_proj;
  logic [ADDR_WIDTH:0]   w_occ_nxt;
  logic [ADDR_WIDTH:0]   w_avail_nxt;
  logic [1:0]            w_ob_cnt_nxt;

  // sram_occ keeps an issued read's address reserved until capture, so the
  // write pointer can never land on an address that is being read.
  assign push_ready  = rstb & (r_sram_occ < C_DEPTH);
  assign w_push_fire = push_valid & push_ready;
  assign pop_valid   = (r_ob_cnt != 2'd0);
  assign w_pop_fire  = pop_valid & pop_ready;
  assign pop_data    = r_ob0;
  assign level       = r_level;

  // Projected buffer occupancy after this edge; a new read lands one edge later.
  assign w_ob_proj    = {1'b0, r_ob_cnt} + {2'b00, r_inflight} - {2'b00, w_pop_fire};
  assign w_issue      = (r_avail != '0) && (w_ob_proj < 3'd2);
  assign w_ob_cnt_nxt = w_ob_proj[1:0];
  assign w_occ_nxt    = r_sram_occ + {{ADDR_WIDTH{1'b0}}, w_push_fire}
                                   - {{ADDR_WIDTH{1'b0}}, r_inflight};
  assign w_avail_nxt  = r_avail + {{ADDR_WIDTH{1'b0}}, w_push_fire}
                                - {{ADDR_WIDTH{1'b0}}, w_issue};

  assign sram_csb0  = ~w_push_fire;
  assign sram_addr0 = r_wr_ptr;
  assign sram_din0  = push_data;
  assign sram_csb1  = ~w_issue;
  assign sram_addr1 = r_rd_ptr;

  always_ff @(posedge clk0 or negedge rstb) begin
    if (!rstb) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_sram_occ <= '0;
      r_avail    <= '0;
      r_inflight <= 1'b0;
      r_ob_cnt   <= 2'd0;
      r_level    <= '0;
    end else begin
      if (w_push_fire) begin
        r_wr_ptr <= (r_wr_ptr == C_LAST) ? '0 : r_wr_ptr + C_ONE;
      end
      if (w_issue) begin
        r_rd_ptr <= (r_rd_ptr == C_LAST) ? '0 : r_rd_ptr + C_ONE;
      end
      r_sram_occ <= w_occ_nxt;
      r_avail    <= w_avail_nxt;
      r_inflight <= w_issue;
      r_ob_cnt   <= w_ob_cnt_nxt;
      r_level    <= w_occ_nxt + {{(ADDR_WIDTH-1){1'b0}}, w_ob_cnt_nxt};
    end
  end

  // Two-entry shift buffer: r_ob0 is always the head.
  always_ff @(posedge clk0 or negedge rstb) begin
    if (!rstb) begin
      r_ob0 <= '0;
      r_ob1 <= '0;
    end else if (w_pop_fire) begin
      if (r_inflight && (r_ob_cnt == 2'd1)) begin
        r_ob0 <= sram_dout1;
      end else begin
        r_ob0 <= r_ob1;
      end
      if (r_inflight && (r_ob_cnt == 2'd2)) begin
        r_ob1 <= sram_dout1;
      end
    end else if (r_inflight) begin
      if (r_ob_cnt == 2'd0) begin
        r_ob0 <= sram_dout1;
      end else begin
        r_ob1 <= sram_dout1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_1w1r_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_1w1r_fifo_ctrl
// Brief   : Self-checking bench with a macro model and a queue-based FIFO model.
// Revision: 1.0
// ============================================================================
module tb_sram_1w1r_fifo_ctrl;

  localparam int DW    = 40;
  localparam int AW    = 7;
  localparam int DEPTH = 128;
  localparam int CAP   = DEPTH + 2;

  logic          clk0 = 1'b0;
  logic          rstb;
  logic          push_valid;
  logic          push_ready;
  logic [DW-1:0] push_data;
  logic          pop_valid;
  logic          pop_ready;
  logic [DW-1:0] pop_data;
  logic [AW:0]   level;
  logic          sram_csb0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic          sram_csb1;
  logic [AW-1:0] sram_addr1;
  logic [DW-1:0] sram_dout1 = '0;

  always #5 clk0 = ~clk0;

  sram_1w1r_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk0(clk0), .rstb(rstb),
    .push_valid(push_valid), .push_ready(push_ready), .push_data(push_data),
    .pop_valid(pop_valid), .pop_ready(pop_ready), .pop_data(pop_data),
    .level(level),
    .sram_csb0(sram_csb0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
  );

  // Macro model: ports latch at posedge, array write and read-out at negedge.
  logic [DW-1:0] mem [0:DEPTH-1];
  logic          m_we = 1'b0;
  logic          m_re = 1'b0;
  logic [AW-1:0] m_wa = '0;
  logic [AW-1:0] m_ra = '0;
  logic [DW-1:0] m_wd = '0;
  int            coll_cnt = 0;

  always @(posedge clk0) begin
    m_we <= (sram_csb0 === 1'b0);
    m_re <= (sram_csb1 === 1'b0);
    m_wa <= sram_addr0;
    m_ra <= sram_addr1;
    m_wd <= sram_din0;
    if (sram_csb0 === 1'b0 && sram_csb1 === 1'b0 && sram_addr0 === sram_addr1) begin
      coll_cnt <= coll_cnt + 1;
      $display("macro: simultaneous read/write to address %0d at %0t", sram_addr0, $time);
    end
  end

  always @(negedge clk0) begin
    if (m_we) mem[m_wa] <= m_wd;
    if (m_re) sram_dout1 <= (m_we && m_wa == m_ra) ? 'x : mem[m_ra];
  end

  // Reference model: the FIFO contents as a plain queue.
  logic [DW-1:0] q[$];
  int            n_cmp = 0;
  int            n_err = 0;
  int            tot_push = 0;
  logic          hold = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic          last_push_fire = 1'b0;
  logic          last_pop_fire = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after negedge, check, update model, wait.
  task automatic cycle(input logic pv, input logic [DW-1:0] pd, input logic pr);
    push_valid = pv;
    push_data  = pd;
    pop_ready  = pr;
    #1;
    chk("level", 64'(level), 64'(q.size()));
    chk("level_cap", 64'(level <= CAP), 64'd1);
    if (q.size() < DEPTH) chk("push_ready_room", 64'(push_ready), 64'd1);
    if (q.size() >= CAP)  chk("push_ready_full", 64'(push_ready), 64'd0);
    if (q.size() == 0)    chk("pop_valid_empty", 64'(pop_valid), 64'd0);
    if (hold) begin
      chk("hold_valid", 64'(pop_valid), 64'd1);
      chk("hold_data", 64'(pop_data), 64'(hold_data));
    end
    last_push_fire = pv && push_ready;
    last_pop_fire  = pop_valid && pr;
    if (last_pop_fire) begin
      if (q.size() == 0) chk("pop_underflow", 64'd1, 64'd0);
      else chk("pop_data", 64'(pop_data), 64'(q.pop_front()));
    end
    if (last_push_fire) begin
      chk("wr_csb", 64'(sram_csb0), 64'd0);
      chk("wr_addr", 64'(sram_addr0), 64'(tot_push % DEPTH));
      chk("wr_din", 64'(sram_din0), 64'(pd));
      q.push_back(pd);
      tot_push++;
    end else begin
      chk("wr_idle", 64'(sram_csb0), 64'd1);
    end
    hold      = pop_valid && !pr;
    hold_data = pop_data;
    @(negedge clk0);
  endtask

  logic [DW-1:0] d;
  logic [63:0]   rnd;
  int            n_acc;
  int            n;

  initial begin
    rstb = 1'b0; push_valid = 1'b1; push_data = '1; pop_ready = 1'b1;
    #2;
    chk("rst_push_ready", 64'(push_ready), 64'd0);
    chk("rst_pop_valid", 64'(pop_valid), 64'd0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_csb0", 64'(sram_csb0), 64'd1);
    chk("rst_csb1", 64'(sram_csb1), 64'd1);
    @(negedge clk0); @(negedge clk0);
    rstb = 1'b1; push_valid = 1'b0;

    // Single word latency
    cycle(1'b0, '0, 1'b0);
    cycle(1'b1, 40'h12_3456_789A, 1'b0);
    #1;
    chk("single_issue", 64'(sram_csb1), 64'd0);
    chk("single_lat0", 64'(pop_valid), 64'd0);
    cycle(1'b0, '0, 1'b0);
    #1 chk("single_lat1", 64'(pop_valid), 64'd0);
    cycle(1'b0, '0, 1'b0);
    #1;
    chk("single_valid", 64'(pop_valid), 64'd1);
    chk("single_data", 64'(pop_data), 64'h12_3456_789A);
    cycle(1'b0, '0, 1'b1);
    cycle(1'b0, '0, 1'b0);

    // Fill to capacity, then drain in order
    d = 40'hA0_0000_0000; n_acc = 0;
    for (int i = 0; i < 140; i++) begin
      cycle(1'b1, d, 1'b0);
      if (last_push_fire) begin n_acc++; d = d + 1'b1; end
    end
    #1;
    chk("fill_count", 64'(n_acc), 64'(CAP));
    chk("fill_level", 64'(level), 64'(CAP));
    chk("fill_ready", 64'(push_ready), 64'd0);
    for (int i = 0; i < 140 && q.size() > 0; i++) cycle(1'b0, '0, 1'b1);
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
    chk("drain_level", 64'(level), 64'd0);

    // Streaming with pointer wrap
    d = 40'h55_0000_0000;
    for (int i = 0; i < 300; i++) begin
      cycle(1'b1, d, 1'b1);
      chk("stream_push", 64'(last_push_fire), 64'd1);
      if (last_push_fire) d = d + 1'b1;
      if (i >= 3) chk("stream_rate", 64'(last_pop_fire), 64'd1);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) cycle(1'b0, '0, 1'b1);
    chk("stream_empty", 64'(q.size()), 64'd0);

    // Random backpressure: push-heavy first half, pop-heavy second half
    n = 0;
    for (int c = 0; c < 20000 && (n < 2000 || q.size() > 0); c++) begin
      rnd = {$urandom(), $urandom()};
      cycle((n < 2000) && ($urandom_range(0, 3) < ((n < 1000) ? 3 : 1)),
            rnd[DW-1:0], 1'($urandom_range(0, 1)));
      if (last_push_fire) n++;
    end
    chk("rand_count", 64'(n), 64'd2000);
    chk("rand_empty", 64'(q.size()), 64'd0);

    // Asynchronous reset mid-stream at level 50
    for (int i = 0; i < 50; i++) cycle(1'b1, 40'(i + 1000), 1'b0);
    #1 chk("pre_rst_level", 64'(level), 64'd50);
    #1 rstb = 1'b0;
    #1;
    chk("arst_push_ready", 64'(push_ready), 64'd0);
    chk("arst_pop_valid", 64'(pop_valid), 64'd0);
    chk("arst_level", 64'(level), 64'd0);
    chk("arst_csb0", 64'(sram_csb0), 64'd1);
    chk("arst_csb1", 64'(sram_csb1), 64'd1);
    q.delete(); tot_push = 0; hold = 1'b0;
    @(negedge clk0);
    rstb = 1'b1; push_valid = 1'b0;
    #1 chk("rel_push_ready", 64'(push_ready), 64'd1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
    cycle(1'b1, 40'h77_7777_7777, 1'b1);
    for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b1);
    chk("post_rst_empty", 64'(q.size()), 64'd0);

    chk("collisions", 64'(coll_cnt), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
